// File: rtl/regfile_access_ctrl.sv
// Port sequencer for the 36-entry register file. After reset it zeroes every
// writable entry, then arbitrates between the core and a single-outstanding debug port.
module regfile_access_ctrl #(
  parameter int NUM_REGS       = 36,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        core_wr_en_i,
  input  logic [5:0]  core_wr_sel_i,
  input  logic [31:0] core_wr_data_i,
  input  logic [5:0]  core_rd1_sel_i,
  input  logic [5:0]  core_rd2_sel_i,
  output logic        core_stall_o,
  input  logic        dbg_req_i,
  input  logic        dbg_we_i,
  input  logic [5:0]  dbg_sel_i,
  input  logic [31:0] dbg_wdata_i,
  output logic        dbg_ack_o,
  output logic [31:0] dbg_rdata_o,
  output logic [31:0] rf_in_o,
  output logic [5:0]  rf_in_sel_o,
  output logic        rf_in_en_o,
  output logic [5:0]  rf_out1_sel_o,
  output logic [5:0]  rf_out2_sel_o,
  input  logic [31:0] rf_out1_i
);

  localparam logic [5:0] LAST_SEL   = 6'(NUM_REGS - 1);
  localparam logic [6:0] NUM_REGS_W = 7'(NUM_REGS);

  typedef enum logic [2:0] {
    ST_CLEAR   = 3'd0,
    ST_IDLE    = 3'd1,
    ST_ACCESS  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_ACK     = 3'd4
  } state_t;

  state_t      state_reg;
  logic [5:0]  clr_cnt_reg;
  logic        dbg_we_reg;
  logic [5:0]  dbg_sel_reg;
  logic [31:0] dbg_wdata_reg;
  logic [31:0] dbg_rdata_reg;
  logic        dbg_sel_ok;

  // x0 and anything beyond the last entry are not reachable from the debug port.
  assign dbg_sel_ok = (dbg_sel_reg != 6'd0) && ({1'b0, dbg_sel_reg} < NUM_REGS_W);

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      if (CLEAR_ON_RESET) begin
        state_reg <= ST_CLEAR;
      end else begin
        state_reg <= ST_IDLE;
      end
      clr_cnt_reg   <= 6'd1;
      dbg_we_reg    <= 1'b0;
      dbg_sel_reg   <= 6'd0;
      dbg_wdata_reg <= 32'd0;
      dbg_rdata_reg <= 32'd0;
    end else begin
      case (state_reg)
        ST_CLEAR: begin
          clr_cnt_reg <= clr_cnt_reg + 6'd1;
          if (clr_cnt_reg == LAST_SEL) begin
            state_reg <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (dbg_req_i) begin
            dbg_we_reg    <= dbg_we_i;
            dbg_sel_reg   <= dbg_sel_i;
            dbg_wdata_reg <= dbg_wdata_i;
            state_reg     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          state_reg <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          // Read data launched in ACCESS is on rf_out1_i during this cycle.
          if (!dbg_we_reg) begin
            dbg_rdata_reg <= dbg_sel_ok ? rf_out1_i : 32'd0;
          end
          state_reg <= ST_ACK;
        end
        ST_ACK: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    rf_in_o       = 32'd0;
    rf_in_sel_o   = 6'd0;
    rf_in_en_o    = 1'b0;
    rf_out1_sel_o = dbg_sel_reg;
    case (state_reg)
      ST_CLEAR: begin
        rf_in_en_o  = 1'b1;
        rf_in_sel_o = clr_cnt_reg;
      end
      ST_IDLE: begin
        rf_in_en_o    = core_wr_en_i;
        rf_in_sel_o   = core_wr_sel_i;
        rf_in_o       = core_wr_data_i;
        rf_out1_sel_o = core_rd1_sel_i;
      end
      ST_ACCESS: begin
        if (dbg_we_reg) begin
          rf_in_en_o  = dbg_sel_ok;
          rf_in_sel_o = dbg_sel_reg;
          rf_in_o     = dbg_wdata_reg;
        end
      end
      default: begin
        rf_in_en_o = 1'b0;
      end
    endcase
    // The write port must stay quiet for the whole time reset is held.
    if (reset_i) begin
      rf_in_en_o = 1'b0;
    end
  end

  assign core_stall_o  = (state_reg != ST_IDLE);
  assign dbg_ack_o     = (state_reg == ST_ACK);
  assign dbg_rdata_o   = dbg_rdata_reg;
  assign rf_out2_sel_o = core_rd2_sel_i;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Randomized bench for regfile_access_ctrl: a behavioural register-file model
// predicts writes, stalls and debug results; a negedge monitor scores the DUT.
module tb_regfile_access_ctrl;

  localparam int NREG      = 36;
  localparam int CLEAR_LEN = NREG - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_i        = 1'b0;
  logic        core_wr_en_i   = 1'b0;
  logic [5:0]  core_wr_sel_i  = '0;
  logic [31:0] core_wr_data_i = '0;
  logic [5:0]  core_rd1_sel_i = '0;
  logic [5:0]  core_rd2_sel_i = '0;
  logic        dbg_req_i      = 1'b0;
  logic        dbg_we_i       = 1'b0;
  logic [5:0]  dbg_sel_i      = '0;
  logic [31:0] dbg_wdata_i    = '0;
  logic        core_stall_o;
  logic        dbg_ack_o;
  logic [31:0] dbg_rdata_o;
  logic [31:0] rf_in_o;
  logic [5:0]  rf_in_sel_o;
  logic        rf_in_en_o;
  logic [5:0]  rf_out1_sel_o;
  logic [5:0]  rf_out2_sel_o;
  logic [31:0] rf_out1_i;

  regfile_access_ctrl #(.NUM_REGS(NREG), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .reset_i(reset_i),
    .core_wr_en_i(core_wr_en_i), .core_wr_sel_i(core_wr_sel_i), .core_wr_data_i(core_wr_data_i),
    .core_rd1_sel_i(core_rd1_sel_i), .core_rd2_sel_i(core_rd2_sel_i), .core_stall_o(core_stall_o),
    .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_sel_i(dbg_sel_i), .dbg_wdata_i(dbg_wdata_i),
    .dbg_ack_o(dbg_ack_o), .dbg_rdata_o(dbg_rdata_o),
    .rf_in_o(rf_in_o), .rf_in_sel_o(rf_in_sel_o), .rf_in_en_o(rf_in_en_o),
    .rf_out1_sel_o(rf_out1_sel_o), .rf_out2_sel_o(rf_out2_sel_o), .rf_out1_i(rf_out1_i)
  );

  // The register file itself: x0 ignores writes, synchronous one-cycle read.
  logic [31:0] rf_mem [64];
  logic        preload = 1'b1;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) rf_mem[i] <= 32'hFFFF_FFFF;
    end else if (rf_in_en_o && rf_in_sel_o != 6'd0 && int'(rf_in_sel_o) < NREG) begin
      rf_mem[rf_in_sel_o] <= rf_in_o;
    end
    rf_out1_i <= (int'(rf_out1_sel_o) < NREG) ? rf_mem[rf_out1_sel_o] : 32'h0;
  end

  typedef struct { bit stall; logic [31:0] rdata; bit chk_rd1; logic [5:0] rd1; logic [5:0] rd2; } cyc_t;
  typedef struct { int cyc; logic [5:0] sel; logic [31:0] data; } wr_t;
  typedef struct { int cyc; bit is_rd; logic [5:0] sel; logic [31:0] rdata; } ack_t;
  typedef struct { bit we; logic [5:0] sel; logic [31:0] wdata; } cmd_t;

  cyc_t cq[$];
  wr_t  wq[$];
  ack_t aq[$];
  cmd_t cmdq[$];

  logic [31:0] ref_regs [64];
  int          clear_left = 0;
  int          clear_next = 1;
  int          busy_left  = 0;
  int          rst_hold   = 0;
  cmd_t        txn;
  logic [31:0] txn_rdata;
  logic [31:0] exp_rdata = '0;
  int          cyc   = 0;
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  function automatic bit sel_ok(input logic [5:0] s);
    return (s != 6'd0) && (int'(s) < NREG);
  endfunction

  task automatic push_cmd(input bit we, input logic [5:0] sel, input logic [31:0] wdata);
    cmd_t c;
    c.we = we; c.sel = sel; c.wdata = wdata;
    cmdq.push_back(c);
  endtask

  // One clock cycle: drive inputs just after the edge and advance the reference model.
  task automatic run_cycle(input bit wen, input logic [5:0] wsel, input logic [31:0] wdata);
    cyc_t e;
    wr_t  w;
    ack_t a;
    @(posedge clk);
    #1;
    cyc++;
    core_wr_en_i   = wen;
    core_wr_sel_i  = wsel;
    core_wr_data_i = wdata;
    core_rd1_sel_i = 6'($urandom_range(0, 63));
    core_rd2_sel_i = 6'($urandom_range(0, 63));
    e.rd1 = core_rd1_sel_i;
    e.rd2 = core_rd2_sel_i;
    e.chk_rd1 = 1'b0;
    if (rst_hold > 0) begin
      rst_hold--;
      reset_i    = 1'b1;
      dbg_req_i  = 1'b0;
      clear_left = CLEAR_LEN;
      clear_next = 1;
      busy_left  = 0;
      exp_rdata  = '0;
      cmdq.delete();
      aq.delete();
      e.stall = 1'b1;
      e.rdata = '0;
      cq.push_back(e);
      return;
    end
    reset_i = 1'b0;
    preload = 1'b0;
    if (busy_left == 1) cmdq.delete(0);
    dbg_req_i = (cmdq.size() > 0);
    if (cmdq.size() > 0) begin
      dbg_we_i    = cmdq[0].we;
      dbg_sel_i   = cmdq[0].sel;
      dbg_wdata_i = cmdq[0].wdata;
    end
    e.stall = (clear_left > 0) || (busy_left > 0);
    if (clear_left > 0) begin
      w.cyc = cyc; w.sel = 6'(clear_next); w.data = '0;
      wq.push_back(w);
      ref_regs[clear_next] = '0;
      clear_next++;
      clear_left--;
    end else if (busy_left > 0) begin
      if (busy_left == 3 && txn.we && sel_ok(txn.sel)) begin
        w.cyc = cyc; w.sel = txn.sel; w.data = txn.wdata;
        wq.push_back(w);
        ref_regs[txn.sel] = txn.wdata;
      end
      if (busy_left == 1 && !txn.we) exp_rdata = txn_rdata;
      busy_left--;
    end else begin
      e.chk_rd1 = 1'b1;
      if (wen) begin
        w.cyc = cyc; w.sel = wsel; w.data = wdata;
        wq.push_back(w);
        if (sel_ok(wsel)) ref_regs[wsel] = wdata;
      end
      if (dbg_req_i) begin
        txn       = cmdq[0];
        txn_rdata = sel_ok(txn.sel) ? ref_regs[txn.sel] : 32'h0;
        busy_left = 3;
        a.cyc = cyc + 3; a.is_rd = !txn.we; a.sel = txn.sel; a.rdata = txn_rdata;
        aq.push_back(a);
      end
    end
    e.rdata = exp_rdata;
    cq.push_back(e);
  endtask

  task automatic rand_cycle();
    run_cycle(1'($urandom_range(0, 1)), 6'($urandom_range(0, NREG - 1)), $urandom);
  endtask

  task automatic quiet_cycle();
    run_cycle(1'b0, 6'($urandom_range(0, NREG - 1)), $urandom);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 400 && (clear_left > 0 || busy_left > 0 || cmdq.size() > 0); n++) quiet_cycle();
  endtask

  // Monitor: scores every cycle half a period after the stimulus edge.
  initial begin
    cyc_t e;
    wr_t  w;
    ack_t a;
    bit   exp_en;
    bit   exp_ack;
    forever begin
      @(negedge clk);
      if (cq.size() > 0) begin
        e = cq.pop_front();
        check("stall", 32'(core_stall_o), 32'(e.stall));
        check("rdata_hold", dbg_rdata_o, e.rdata);
        check("rd2_sel", 32'(rf_out2_sel_o), 32'(e.rd2));
        if (e.chk_rd1) check("rd1_sel", 32'(rf_out1_sel_o), 32'(e.rd1));
        exp_en = (wq.size() > 0) && (wq[0].cyc == cyc);
        check("wr_en", 32'(rf_in_en_o), 32'(exp_en));
        if (exp_en) begin
          w = wq.pop_front();
          if (rf_in_en_o) begin
            check("wr_sel", 32'(rf_in_sel_o), 32'(w.sel));
            check("wr_data", rf_in_o, w.data);
          end
        end
        exp_ack = (aq.size() > 0) && (aq[0].cyc == cyc);
        check("ack", 32'(dbg_ack_o), 32'(exp_ack));
        if (exp_ack) begin
          a = aq.pop_front();
          $display("dbg txn cyc=%0d %s sel=%0d rdata=%h", cyc, a.is_rd ? "rd" : "wr", a.sel, dbg_rdata_o);
          if (dbg_ack_o && a.is_rd) check("ack_rdata", dbg_rdata_o, a.rdata);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) ref_regs[i] = 32'hFFFF_FFFF;
    // Power-up reset with the file preloaded, then a debug read held across the clear.
    rst_hold = 3;
    repeat (3) quiet_cycle();
    repeat (10) rand_cycle();
    push_cmd(1'b0, 6'd5, 32'h0);
    wait_idle();
    repeat (6) rand_cycle();
    push_cmd(1'b1, 6'd5, 32'hDEAD_BEEF);
    wait_idle();
    quiet_cycle();
    push_cmd(1'b0, 6'd5, 32'h0);
    wait_idle();
    run_cycle(1'b1, 6'd34, 32'h1234_5678);
    push_cmd(1'b0, 6'd34, 32'h0);
    wait_idle();
    // Out-of-range debug targets.
    push_cmd(1'b1, 6'd0, 32'hA5A5_A5A5);
    push_cmd(1'b1, 6'd40, 32'hA5A5_A5A5);
    push_cmd(1'b0, 6'd40, 32'h0);
    wait_idle();
    // Core write in the acceptance cycle lands; the one during stall is dropped.
    push_cmd(1'b1, 6'd9, 32'h0000_0099);
    run_cycle(1'b1, 6'd7, 32'h0000_0011);
    run_cycle(1'b1, 6'd7, 32'h0000_0022);
    wait_idle();
    push_cmd(1'b0, 6'd7, 32'h0);
    wait_idle();
    // Back-to-back requests with the request line held.
    for (int i = 0; i < 4; i++) push_cmd(1'($urandom_range(0, 1)), 6'($urandom_range(1, NREG - 1)), $urandom);
    wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (cmdq.size() == 0 && $urandom_range(0, 5) == 0)
        push_cmd(1'($urandom_range(0, 1)), 6'($urandom_range(0, 45)), $urandom);
      rand_cycle();
    end
    wait_idle();
    // Reset partway through the clear sweep.
    rst_hold = 2;
    repeat (2) quiet_cycle();
    for (int n = 0; n < 100 && clear_next < 20; n++) quiet_cycle();
    rst_hold = 2;
    repeat (2) quiet_cycle();
    wait_idle();
    repeat (4) rand_cycle();
    // Reset while a debug write sits in its access cycle.
    wait_idle();
    push_cmd(1'b1, 6'd12, 32'hCAFE_F00D);
    for (int n = 0; n < 100 && busy_left != 3; n++) quiet_cycle();
    rst_hold = 2;
    repeat (2) quiet_cycle();
    wait_idle();
    push_cmd(1'b0, 6'd12, 32'h0);
    wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (cmdq.size() == 0 && $urandom_range(0, 3) == 0)
        push_cmd(1'($urandom_range(0, 1)), 6'($urandom_range(0, 45)), $urandom);
      rand_cycle();
    end
    wait_idle();
    repeat (3) quiet_cycle();
    @(negedge clk);
    #1;
    check("wq_drained", 32'(wq.size()), 32'd0);
    check("aq_drained", 32'(aq.size()), 32'd0);
    for (int i = 0; i < NREG; i++) check("mem", rf_mem[i], ref_regs[i]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_access_ctrl.md
# regfile_access_ctrl

Sequencer and arbiter in front of the 36-entry CPU register file (x0–x31, q0–q3, 6-bit select, synchronous 1-cycle read, x0 write-ignored). It owns the file's write port and read port 1. After reset it zeroes every writable entry. It then shares the ports between the core pipeline and a single-outstanding debug/host access port, stalling the core while a debug transaction runs.

## Interface
- `NUM_REGS`, 36, number of register entries (select width fixed at 6).
- `CLEAR_ON_RESET`, 1, 1 = run clear sequence after reset; 0 = go straight to IDLE.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset_i` input 1: asynchronous, active-high reset.
- `core_wr_en_i` input 1: core write-back enable.
- `core_wr_sel_i` input 6: core write-back register.
- `core_wr_data_i` input 32: core write-back data.
- `core_rd1_sel_i` input 6: core read port 1 select.
- `core_rd2_sel_i` input 6: core read port 2 select.
- `core_stall_o` output 1: core must hold its pipeline; high whenever state ≠ IDLE.
- `dbg_req_i` input 1: debug access request; level, held until ack.
- `dbg_we_i` input 1: 1 = write, 0 = read.
- `dbg_sel_i` input 6: debug target register.
- `dbg_wdata_i` input 32: debug write data.
- `dbg_ack_o` output 1: one-cycle completion pulse.
- `dbg_rdata_o` output 32: read result, valid with ack and held until next read completes.
- `rf_in_o` output 32: register file write data.
- `rf_in_sel_o` output 6: register file write select.
- `rf_in_en_o` output 1: register file write enable.
- `rf_out1_sel_o` output 6: register file read port 1 select.
- `rf_out2_sel_o` output 6: register file read port 2 select; always `core_rd2_sel_i`.
- `rf_out1_i` input 32: register file read port 1 data.

## Operation
- States: CLEAR, IDLE, ACCESS, CAPTURE, ACK. The state and a 6-bit clear counter are registered. All `rf_*` and `core_stall_o` outputs decode combinationally from state.
- CLEAR:
  - Drives en=1, sel=counter, data=0, so one entry is cleared per cycle.
  - The counter starts at 1 and increments each edge.
  - After the edge that writes entry `NUM_REGS-1`, the state goes to IDLE.
  - x0 is never written.
- IDLE:
  - The core owns the ports: `rf_in_*` = `core_wr_*` and `rf_out1_sel_o` = `core_rd1_sel_i`.
  - If `dbg_req_i` is sampled high at an edge, latch `dbg_we_i`, `dbg_sel_i` and `dbg_wdata_i`, and go to ACCESS.
  - The core's write in the acceptance cycle completes normally.
- ACCESS:
  - Write: en=1, sel and data from the latched values.
  - Read: en=0 and `rf_out1_sel_o` = latched select.
  - Next state is CAPTURE.
- CAPTURE:
  - On a read, `dbg_rdata_o` is registered from `rf_out1_i` at this edge.
  - Next state is ACK.
- ACK: `dbg_ack_o`=1 for this cycle only, then go to IDLE.
- If `dbg_req_i` is still high in IDLE after ACK, a new transaction starts. The requester drops `dbg_req_i` during the ack cycle.
- In every state other than IDLE, core write requests are dropped. `rf_out1_sel_o` is core-driven only in IDLE.
- Debug select 0 or select ≥ `NUM_REGS`:
  - Write: en is suppressed.
  - Read: `dbg_rdata_o` = 0.
  - Ack timing is unchanged.
- `dbg_req_i` during CLEAR is ignored until IDLE; the request is held, not lost.

## Timing
- Reset values (forced while `reset_i` high):
  - State = CLEAR (or IDLE if `CLEAR_ON_RESET`=0), counter=1.
  - `rf_in_en_o`=0 unconditionally while `reset_i` is high.
  - `core_stall_o`=`CLEAR_ON_RESET`, `dbg_ack_o`=0, `dbg_rdata_o`=0.
- Clear duration is `NUM_REGS-1` = 35 edges after reset release. `core_stall_o` falls in the cycle following the edge that writes entry 35.
- Debug latency:
  - Acceptance edge E.
  - `core_stall_o` high in cycles E+1..E+3.
  - `dbg_ack_o` high in cycle E+3.
  - IDLE again from E+4.
- Throughput: one debug transaction per 4 cycles with `dbg_req_i` held high.
- Reset mid-CLEAR or mid-transaction:
  - The sequence restarts from counter=1.
  - The pending transaction is abandoned with no ack.
  - `dbg_rdata_o` returns to 0.
- Simultaneous core write and debug acceptance in the same IDLE cycle: the core write lands, and the debug access follows.

## Test plan
- Reset release with file preloaded to 0xFFFFFFFF → exactly 35 writes of 0 to sel 1..35 on consecutive edges, `core_stall_o` low at cycle 36, x0 never written.
- Debug write x5=0xDEADBEEF, then core read rd1=5 → write lands in ACCESS, ack at E+3, `rf_out1_i`=0xDEADBEEF one cycle after core read.
- Core writes q2 (sel 34)=0x12345678, then debug read sel 34 → `dbg_rdata_o`=0x12345678 with `dbg_ack_o` pulse, stall high exactly 3 cycles.
- Debug write sel 0 and sel 40 with 0xA5A5A5A5 → `rf_in_en_o` never high, acks delivered; debug read sel 40 → 0.
- Core write x7=0x11 in the same cycle `dbg_req_i` is first seen, plus a core write during stall → x7=0x11 written, stalled write dropped.
- Assert `reset_i` at clear counter 20, and again during ACCESS of a debug write → clear restarts at sel 1, no ack, no write from the abandoned transaction.
